ram_64_8_wr_ctrl: RTL and testbench
===================================

RAM_64_8_WR_CTRL -- requirements
Module: ram_64_8_wr_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DW, 8, data width.
- AW, 6, RAM address width.
- DEPTH, 64, RAM word count; equals 2**AW.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- SYS_CLK, in, 1, sole clock; the integrator also ties the RAM C_CLK to it.
- SYS_RST, in, 1, asynchronous active-high reset.
- S_DATA, in, DW, inbound byte.
- S_VALID, in, 1, S_DATA valid.
- S_LAST, in, 1, final byte of frame; qualified by S_VALID.
- S_READY, out, 1, controller accepts beat.
- C_ADDR, out, AW, RAM write address.
- C_DIN, out, DW, RAM write data.
- C_WEN, out, 1, RAM write enable, active high.
- FRM_RDY, out, 1, complete frame resident in RAM.
- FRM_LEN, out, AW+1, frame byte count, 1..64; valid while FRM_RDY.
- FRM_ACK, in, 1, consumer finished reading the frame.
- OVF_PULSE, out, 1, one-cycle pulse when an oversize frame is dropped.
- DROP_CNT, out, 8, saturating count of dropped frames.

Function
REQ-003 SHALL implement states FILL, HOLD and DROP.
REQ-004 SHALL define a beat as accepted on a rising edge where S_VALID and S_READY are both 1.
REQ-005 S_READY SHALL be 1 in FILL and DROP, and 0 in HOLD.
REQ-006 In FILL, an accepted beat SHALL register C_ADDR<=wptr, C_DIN<=S_DATA and C_WEN<=1; the RAM commits the write on the following edge.
REQ-007 C_WEN SHALL be 0 in any cycle following an edge with no accepted FILL beat.
REQ-008 C_ADDR, C_DIN and C_WEN SHALL be driven only from registers.
REQ-009 wptr SHALL start at 0 in FILL and increment by 1 per accepted FILL beat.
REQ-010 FILL beat with S_LAST=1 SHALL:
- latch FRM_LEN<=wptr+1;
- move the state to HOLD.
REQ-011 FRM_RDY SHALL rise one edge after the edge accepting the last beat, so the last write is committed before FRM_RDY is seen.
REQ-012 FILL beat at wptr=63 with S_LAST=0 SHALL:
- perform the write;
- move the state to DROP.
REQ-013 A 64-byte frame with S_LAST on byte 64 SHALL be legal and SHALL go to HOLD with FRM_LEN=64.
REQ-014 DROP SHALL accept and discard beats with no write.
REQ-015 On the DROP beat carrying S_LAST, the block SHALL:
- pulse OVF_PULSE for one cycle;
- increment DROP_CNT, saturating at 255;
- return to FILL with wptr=0.
REQ-016 HOLD SHALL keep FRM_RDY=1 and FRM_LEN stable until FRM_ACK=1 is sampled.
REQ-017 On FRM_ACK=1 in HOLD, the next edge SHALL:
- clear FRM_RDY;
- set wptr=0;
- enter FILL.
REQ-018 S_VALID during the ACK cycle SHALL NOT be accepted, since S_READY=0; that beat is accepted on the next cycle.
REQ-019 FRM_ACK outside HOLD SHALL be ignored.
REQ-020 FRM_ACK held high SHALL cause no repeat effect; the next frame requires a new S_LAST.
REQ-021 wptr arithmetic SHALL be AW bits and never wrap within a frame; the DROP transition precedes any wrap.

Reset
REQ-022 On SYS_RST=1, the block SHALL asynchronously set:
- state=FILL, wptr=0;
- C_ADDR=0, C_DIN=0, C_WEN=0;
- FRM_RDY=0, FRM_LEN=0;
- OVF_PULSE=0, DROP_CNT=0.
REQ-023 Reset mid-frame, in DROP or in HOLD SHALL discard the partial or pending frame without an OVF_PULSE; RAM contents are not cleared.
REQ-024 Reset release SHALL be synchronised externally; the block needs no internal synchroniser.

Structure
REQ-025 Package ram_64_8_pkg SHALL hold:
- DW, AW, DEPTH;
- LEN_W=AW+1;
- the state enum {FILL, HOLD, DROP}.
REQ-026 SHALL be a single module with no sub-module; integration instantiates it beside the 64x8 dual-port RAM and connects C_ADDR, C_DIN and C_WEN directly.

Verification
REQ-027 3-byte frame 0xA1,0xA2,0xA3 with S_LAST on 3rd -> C_WEN pulses with C_ADDR 0,1,2; FRM_RDY rises one edge after the last write; FRM_LEN=3.
REQ-028 64-byte frame, S_LAST on byte 64 -> final write C_ADDR=63; FRM_LEN=64; no OVF_PULSE.
REQ-029 70-byte frame -> writes to addresses 0..63, then DROP; OVF_PULSE once at byte 70; DROP_CNT=1; next frame writes from address 0.
REQ-030 In HOLD, S_VALID held high with FRM_ACK pulsed -> no beat accepted in the ACK cycle; first byte accepted the next cycle at C_ADDR=0.
REQ-031 SYS_RST asserted after byte 10 of a frame -> all outputs at reset values immediately; a following 2-byte frame gives FRM_LEN=2.
REQ-032 256 oversize frames -> DROP_CNT saturates at 255.

Source files
------------

// File: rtl/ram_64_8_pkg.sv
// Shared definitions for the 64x8 frame-buffer write controller.
// Holds the RAM geometry and the controller state encoding.
// No logic lives here; the top imports it.
package ram_64_8_pkg;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int LEN_W = AW + 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ram_64_8_wr_ctrl.sv
// Purpose: stream bytes into a 64x8 RAM as one frame, hand it to a consumer, drop oversize frames.
// Latency: write issued one edge after beat acceptance; FRM_RDY rises one edge after the last write is issued.
// Backpressure: S_READY low only while a complete frame is held; oversize tails are accepted and discarded.
module ram_64_8_wr_ctrl #(
    parameter int DW    = ram_64_8_pkg::DW,
    parameter int AW    = ram_64_8_pkg::AW,
    parameter int DEPTH = ram_64_8_pkg::DEPTH
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RST,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    input  logic          S_LAST,
    output logic          S_READY,
    output logic [AW-1:0] C_ADDR,
    output logic [DW-1:0] C_DIN,
    output logic          C_WEN,
    output logic          FRM_RDY,
    output logic [AW:0]   FRM_LEN,
    input  logic          FRM_ACK,
    output logic          OVF_PULSE,
    output logic [7:0]    DROP_CNT
);

    import ram_64_8_pkg::*;

    // Frame length needs one more bit than the address so a full 64-byte frame fits.
    localparam int            FL_W      = AW + 1;
    // Highest writable address; reaching it without S_LAST means the frame is oversize.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    wr_state_t     state;
    logic [AW-1:0] wptr;
    logic          beat_acc;

    assign beat_acc = S_VALID & S_READY;

    // Single FSM: owns the write port, frame handshake, drop accounting and ready.
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state     <= FILL;
            wptr      <= '0;
            S_READY   <= 1'b1;
            C_ADDR    <= '0;
            C_DIN     <= '0;
            C_WEN     <= 1'b0;
            FRM_RDY   <= 1'b0;
            FRM_LEN   <= '0;
            OVF_PULSE <= 1'b0;
            DROP_CNT  <= '0;
        end else begin
            // Write enable and overflow flag are single-cycle unless re-asserted below.
            C_WEN     <= 1'b0;
            OVF_PULSE <= 1'b0;
            case (state)
                FILL: begin
                    if (beat_acc) begin
                        C_ADDR <= wptr;
                        C_DIN  <= S_DATA;
                        C_WEN  <= 1'b1;
                        if (S_LAST) begin
                            // Last write is still in flight; FRM_RDY follows one edge later.
                            FRM_LEN <= FL_W'(wptr) + FL_W'(1);
                            state   <= HOLD;
                            S_READY <= 1'b0;
                        end else if (wptr == LAST_ADDR) begin
                            // RAM is full and the frame continues: keep pointer, discard the rest.
                            state <= DROP;
                        end else begin
                            wptr <= wptr + AW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!FRM_RDY) begin
                        FRM_RDY <= 1'b1;
                    end else if (FRM_ACK) begin
                        // Release only once the consumer has seen FRM_RDY.
                        FRM_RDY <= 1'b0;
                        wptr    <= '0;
                        state   <= FILL;
                        S_READY <= 1'b1;
                    end
                end
                DROP: begin
                    if (beat_acc && S_LAST) begin
                        OVF_PULSE <= 1'b1;
                        if (DROP_CNT != 8'hFF) begin
                            DROP_CNT <= DROP_CNT + 8'd1;
                        end
                        wptr  <= '0;
                        state <= FILL;
                    end
                end
                default: begin
                    state   <= FILL;
                    wptr    <= '0;
                    S_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_64_8_wr_ctrl.sv
// Bench for the frame-buffer write controller.
// Frames are driven with random data and idle gaps; expectations come from frame length rules.
// A behavioural RAM captures the write port so stored contents can be compared per frame.
module tb_ram_64_8_wr_ctrl;

    logic       SYS_CLK;
    logic       SYS_RST;
    logic [7:0] S_DATA;
    logic       S_VALID;
    logic       S_LAST;
    logic       S_READY;
    logic [5:0] C_ADDR;
    logic [7:0] C_DIN;
    logic       C_WEN;
    logic       FRM_RDY;
    logic [6:0] FRM_LEN;
    logic       FRM_ACK;
    logic       OVF_PULSE;
    logic [7:0] DROP_CNT;

    ram_64_8_wr_ctrl dut (
        .SYS_CLK  (SYS_CLK),
        .SYS_RST  (SYS_RST),
        .S_DATA   (S_DATA),
        .S_VALID  (S_VALID),
        .S_LAST   (S_LAST),
        .S_READY  (S_READY),
        .C_ADDR   (C_ADDR),
        .C_DIN    (C_DIN),
        .C_WEN    (C_WEN),
        .FRM_RDY  (FRM_RDY),
        .FRM_LEN  (FRM_LEN),
        .FRM_ACK  (FRM_ACK),
        .OVF_PULSE(OVF_PULSE),
        .DROP_CNT (DROP_CNT)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    // Behavioural dual-port RAM: commits on the edge after the controller registers a write.
    logic [7:0] ram_mdl [64];
    always @(posedge SYS_CLK) begin
        if (C_WEN) ram_mdl[C_ADDR] <= C_DIN;
    end

    logic [7:0] exp_mem [64];
    int exp_drop;
    int cur_len;
    int n_pass;
    int n_chk;

    task automatic step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one frame of len bytes; base<0 means random data. With overlap, the first byte
    // is presented in the same cycle as the FRM_ACK that releases the previous frame.
    task automatic send_frame(input int len, input int base, input bit overlap);
        logic [7:0] b;
        b = 8'h00;
        if (overlap) begin
            b       = 8'($urandom);
            S_DATA  = b;
            S_VALID = 1'b1;
            S_LAST  = (len == 1);
            FRM_ACK = 1'b1;
            step();
            check("ack_cycle_no_write", C_WEN, 1'b0);
            check("ack_cycle_rdy_clear", FRM_RDY, 1'b0);
            FRM_ACK = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            if (!(overlap && i == 0)) begin
                if ($urandom_range(0, 3) == 0) begin
                    S_VALID = 1'b0;
                    S_LAST  = 1'b0;
                    step();
                    check("gap_no_write", C_WEN, 1'b0);
                end
                b       = (base >= 0) ? 8'(base + i) : 8'($urandom);
                S_DATA  = b;
                S_VALID = 1'b1;
                S_LAST  = (i == len - 1);
                check("ready_before_beat", S_READY, 1'b1);
            end
            step();
            if (i < 64) begin
                check("beat_wen", C_WEN, 1'b1);
                check("beat_addr", C_ADDR, i);
                check("beat_din", C_DIN, b);
                exp_mem[i] = b;
            end else begin
                check("drop_no_write", C_WEN, 1'b0);
            end
            if (i == len - 1 && len > 64) begin
                exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
                check("ovf_pulse", OVF_PULSE, 1'b1);
                check("drop_cnt", DROP_CNT, exp_drop);
            end else if (i == len - 1) begin
                check("no_ovf_legal", OVF_PULSE, 1'b0);
            end
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        if (len <= 64) begin
            cur_len = len;
            check("hold_not_ready", S_READY, 1'b0);
            check("rdy_not_early", FRM_RDY, 1'b0);
            step();
            check("frm_rdy", FRM_RDY, 1'b1);
            check("frm_len", FRM_LEN, len);
            for (int j = 0; j < len; j++) begin
                check("ram_content", ram_mdl[j], exp_mem[j]);
            end
        end else begin
            step();
            check("ovf_one_cycle", OVF_PULSE, 1'b0);
            check("drop_no_frm_rdy", FRM_RDY, 1'b0);
            check("drop_back_ready", S_READY, 1'b1);
        end
    endtask

    // Hold a frame for a few cycles with traffic pushing, then acknowledge it.
    task automatic release_frame();
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
            S_VALID = 1'b1;
            S_DATA  = 8'($urandom);
            step();
            check("hold_rdy_stable", FRM_RDY, 1'b1);
            check("hold_len_stable", FRM_LEN, cur_len);
            check("hold_no_write", C_WEN, 1'b0);
        end
        S_VALID = 1'b0;
        FRM_ACK = 1'b1;
        step();
        check("release_rdy_clear", FRM_RDY, 1'b0);
        check("release_ready", S_READY, 1'b1);
        FRM_ACK = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_chk    = 0;
        exp_drop = 0;
        cur_len  = 0;
        SYS_RST  = 1'b1;
        S_DATA   = 8'h00;
        S_VALID  = 1'b0;
        S_LAST   = 1'b0;
        FRM_ACK  = 1'b0;

        // Reset state
        #12;
        check("rst_wen", C_WEN, 1'b0);
        check("rst_addr", C_ADDR, 0);
        check("rst_din", C_DIN, 0);
        check("rst_frm_rdy", FRM_RDY, 1'b0);
        check("rst_frm_len", FRM_LEN, 0);
        check("rst_ovf", OVF_PULSE, 1'b0);
        check("rst_drop_cnt", DROP_CNT, 0);
        check("rst_ready", S_READY, 1'b1);
        step();
        SYS_RST = 1'b0;

        // Three-byte frame A1,A2,A3
        send_frame(3, 8'hA1, 1'b0);
        release_frame();

        // Full 64-byte frame is legal
        send_frame(64, -1, 1'b0);
        release_frame();

        // 70-byte frame is dropped; next frame restarts at address 0
        send_frame(70, -1, 1'b0);
        send_frame(4, -1, 1'b0);

        // ACK with S_VALID high: byte waits one cycle, then lands at address 0
        send_frame(5, -1, 1'b1);
        release_frame();

        // FRM_ACK held high across a whole frame releases it exactly once
        FRM_ACK = 1'b1;
        send_frame(6, -1, 1'b0);
        step();
        check("held_ack_release", FRM_RDY, 1'b0);
        step();
        check("held_ack_no_repeat_rdy", FRM_RDY, 1'b0);
        check("held_ack_no_repeat_ready", S_READY, 1'b1);
        FRM_ACK = 1'b0;

        // Random lengths spanning legal and oversize
        for (int k = 0; k < 12; k++) begin
            int len;
            len = $urandom_range(1, 80);
            send_frame(len, -1, 1'b0);
            if (len <= 64) release_frame();
        end

        // Reset after byte 10 of a frame
        for (int i = 0; i < 10; i++) begin
            S_DATA  = 8'($urandom);
            S_VALID = 1'b1;
            S_LAST  = 1'b0;
            step();
            check("pre_rst_addr", C_ADDR, i);
        end
        S_VALID = 1'b0;
        #2;
        SYS_RST = 1'b1;
        #1;
        check("mid_rst_wen", C_WEN, 1'b0);
        check("mid_rst_addr", C_ADDR, 0);
        check("mid_rst_din", C_DIN, 0);
        check("mid_rst_frm_rdy", FRM_RDY, 1'b0);
        check("mid_rst_frm_len", FRM_LEN, 0);
        check("mid_rst_ovf", OVF_PULSE, 1'b0);
        check("mid_rst_drop_cnt", DROP_CNT, 0);
        check("mid_rst_ready", S_READY, 1'b1);
        exp_drop = 0;
        step();
        SYS_RST = 1'b0;
        send_frame(2, -1, 1'b0);
        release_frame();

        // 256 oversize frames saturate the drop counter
        for (int k = 0; k < 256; k++) begin
            send_frame(65, -1, 1'b0);
        end
        check("drop_cnt_saturated", DROP_CNT, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
